modadd_stream_ctrl: RTL

Sequential front-end for the combinational modular adder/subtractor core (three-stage s/x/y -> z datapath).
- Accepts operation requests {s, x, y} on a valid/ready stream and buffers them in a small FIFO.
- Drives the core's operand inputs from registers, gives the core one full cycle to settle, then captures z.
- Presents the result on a valid/ready output stream, with an error flag for out-of-range operands.

---
 rtl/modadd_pkg.sv | 24 ++
 rtl/modadd_req_fifo.sv | 56 +++++
 rtl/modadd_stream_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/modadd_pkg.sv
// Shared types and constants for the modular add/sub stream front-end.
// Request payload, FSM state encoding and the operand range check.
package modadd_pkg;

  localparam int OPW         = 4;
  localparam int MODULUS_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  typedef struct packed {
    logic           s;
    logic [OPW-1:0] x;
    logic [OPW-1:0] y;
  } req_t;

  function automatic logic op_out_of_range(input logic [OPW-1:0] v, input int modulus);
    return int'(v) >= modulus;
  endfunction

endpackage

// File: rtl/modadd_req_fifo.sv
// Request FIFO for the modular add/sub front-end.
// Head entry is presented combinationally on rdata; full/empty come from the registered count.
module modadd_req_fifo
  import modadd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  req_t                   wdata,
  output req_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/modadd_stream_ctrl.sv
// Stream front-end for the combinational modular adder/subtractor core.
// Queues requests, drives the core from registers, waits one settle cycle, captures z.
//
//   state  | meaning
//   IDLE   | no request in flight; pops as soon as the FIFO holds an entry
//   SETTLE | core operands loaded, core output settling for one cycle
//   RESP   | result held on out_* until the consumer accepts it
module modadd_stream_ctrl
  import modadd_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_s,
  input  logic [OPW-1:0]         in_x,
  input  logic [OPW-1:0]         in_y,
  output logic                   core_s,
  output logic [OPW-1:0]         core_x,
  output logic [OPW-1:0]         core_y,
  input  logic [OPW-1:0]         core_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPW-1:0]         out_z,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_t state;
  state_t state_nxt;
  req_t   wr_req;
  req_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;
  logic   capture;
  logic   resp_done;
  logic   range_err;

  assign wr_req    = '{s: in_s, x: in_x, y: in_y};
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  modadd_req_fifo #(
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    resp_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) begin
          resp_done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Core operands move only at pop edges, so they are stable across SETTLE and RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_s    <= 1'b0;
      core_x    <= '0;
      core_y    <= '0;
      range_err <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_err   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        core_s    <= head.s;
        core_x    <= head.x;
        core_y    <= head.y;
        range_err <= op_out_of_range(head.x, MODULUS) || op_out_of_range(head.y, MODULUS);
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_z     <= range_err ? '0 : core_z;
        out_err   <= range_err;
      end else if (resp_done) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
